wb_cmd_master: RTL and testbench

Wishbone classic-cycle bus master that drives the GPU's register/memory write port (CR, sprite table, tile map, texture memory) from a command queue. The host-side logic, such as a loader FSM or a soft-CPU bridge, pushes address/data/select commands into an internal FIFO. The block replays each command as one single-beat Wishbone transaction and reports completion or failure per command. It is the initiator counterpart of the GPU's slave port: it owns `cyc/stb/we/sel/adr/dat` and consumes `ack`.

---
 rtl/wb_cmd_master.sv | 149 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle master: replays queued {we, adr, dat, sel} commands as single-beat bus
// cycles and reports each completion. Define WB_MASTER_TIMEOUT_EN to build the ack timeout abort.
module wb_cmd_master #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [26:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [26:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef logic [PtrW:0] ptr_t;

    typedef struct packed {
        logic        we;
        logic [26:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_t;

    state_t state;
    cmd_t   fifo_mem [FIFO_DEPTH];
    cmd_t   head;
    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    logic   fifo_empty;
    logic   fifo_full;
    logic   push;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                        (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr[PtrW-1:0]];

    assign cmd_ready  = !fifo_full;
    assign busy       = !fifo_empty || (state == StActive);

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            fifo_mem[wr_ptr[PtrW-1:0]] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    // Abort on the edge where the count would reach TIMEOUT_CYCLES, so cyc is high that many cycles.
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state     <= StIdle;
            rd_ptr    <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                StIdle: begin
                    if (!fifo_empty) begin
                        wb_we_o  <= head.we;
                        wb_adr_o <= head.adr;
                        wb_dat_o <= head.dat;
                        wb_sel_o <= head.sel;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        rd_ptr   <= rd_ptr + ptr_t'(1);
                        state    <= StActive;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                StActive: begin
                    // ack has priority over a timeout landing on the same edge
                    if (wb_ack_i) begin
                        if (!wb_we_o) begin
                            rsp_dat <= wb_dat_i;
                        end
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= StGap;
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt == TmoLast) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= StGap;
                    end else begin
                        tmo_cnt <= tmo_cnt + TmoW'(1);
                    end
`endif
                end
                // One idle cycle lets a lingering slave ack drain and the slave re-phase on cyc low.
                StGap: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed and random commands against a GPU-style slave, checked by a
// queue-based bus/response model. Build with WB_MASTER_TIMEOUT_EN to exercise the timeout abort.
module tb_wb_cmd_master;
    localparam int unsigned Depth = 4;
    localparam int unsigned Tmo   = 8;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [26:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    logic        clk_100MHz = 1'b0;
    logic        reset_n    = 1'b0;
    logic        cmd_valid  = 1'b0;
    logic        cmd_we     = 1'b0;
    logic [26:0] cmd_adr    = '0;
    logic [31:0] cmd_dat    = '0;
    logic [3:0]  cmd_sel    = '0;
    logic [31:0] wb_dat_i   = '0;
    logic        wb_ack_i   = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_dat, wb_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [26:0] wb_adr_o;

    always #5 clk_100MHz = ~clk_100MHz;

    wb_cmd_master #(
        .FIFO_DEPTH    (Depth),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [26:0] adr);
        if (adr == 27'h1010) return 32'hDEAD_BEEF;
        return {adr[15:0], ~adr[15:0]} ^ 32'h3C5A_96E1;
    endfunction

    // Slave: acks after ack_delay cycles of cyc&stb, keeps ack high for ack_hold cycles.
    int ack_delay = 2;
    int ack_hold  = 1;
    bit ack_never = 1'b0;
    int sl_wait   = 0;
    int sl_hold   = 0;

    always @(posedge clk_100MHz) begin
        if (!reset_n) begin
            wb_ack_i <= 1'b0;
            sl_wait  <= 0;
            sl_hold  <= 0;
        end else if (sl_hold != 0) begin
            wb_ack_i <= 1'b1;
            sl_hold  <= sl_hold - 1;
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i && !ack_never) begin
            if (sl_wait + 1 >= ack_delay) begin
                wb_ack_i <= 1'b1;
                wb_dat_i <= slave_data(wb_adr_o);
                sl_hold  <= ack_hold - 1;
                sl_wait  <= 0;
            end else begin
                wb_ack_i <= 1'b0;
                sl_wait  <= sl_wait + 1;
            end
        end else begin
            wb_ack_i <= 1'b0;
            sl_wait  <= 0;
        end
    end

    // Reference model state
    cmd_t        exp_q[$];
    cmd_t        cur       = '0;
    int          occ       = 0;
    int          prev_occ  = 0;
    int          len       = 0;
    int          n_rsp     = 0;
    int          n_bus     = 0;
    bit          in_flight = 1'b0;
    bit          prev_cyc  = 1'b0;
    bit          prev_ack  = 1'b0;
    bit          prev_gap  = 1'b0;
    bit          mon_en    = 1'b0;
    logic [31:0] last_rdat = '0;

    always @(negedge clk_100MHz) begin
        if (mon_en) begin
            bit   done;
            cmd_t obs;
            done = 1'b0;
            obs  = {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o};
            if (prev_cyc && (prev_ack || (TmoEn && len == int'(Tmo)))) begin
                check("cyc_fall", wb_cyc_o, 1'b0);
                check("stb_fall", wb_stb_o, 1'b0);
                check("rsp_valid", rsp_valid, 1'b1);
                check("rsp_err", rsp_err, !prev_ack);
                if (prev_ack && !cur.we) last_rdat = slave_data(cur.adr);
                check("rsp_dat", rsp_dat, last_rdat);
                in_flight = 1'b0;
                n_rsp++;
                done = 1'b1;
            end else if (prev_cyc) begin
                check("cyc_hold", wb_cyc_o, 1'b1);
                check("stb_hold", wb_stb_o, 1'b1);
                check("no_rsp_active", rsp_valid, 1'b0);
                check("bus_stable", obs, cur);
                len++;
            end else begin
                check("no_rsp_idle", rsp_valid, 1'b0);
                check("start_timing", wb_cyc_o, !prev_gap && prev_occ != 0);
                check("stb_eq_cyc", wb_stb_o, wb_cyc_o);
                if (wb_cyc_o) begin
                    check("bus_cmd_avail", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    check("bus_cmd", obs, cur);
                    len = 1;
                    occ--;
                    in_flight = 1'b1;
                    n_bus++;
                end else begin
                    check("idle_hold", obs, cur);
                end
            end
            check("cmd_ready", cmd_ready, occ < int'(Depth));
            check("busy", busy, occ != 0 || in_flight);
            prev_cyc = wb_cyc_o;
            prev_ack = wb_ack_i;
            prev_gap = done;
            prev_occ = occ;
        end
    end

    task automatic push(input cmd_t c);
        int guard = 0;
        @(negedge clk_100MHz);
        while (!cmd_ready && guard < 200) begin
            guard++;
            @(negedge clk_100MHz);
        end
        check("push_ready", cmd_ready, 1'b1);
        if (cmd_ready) begin
            cmd_valid = 1'b1;
            {cmd_we, cmd_adr, cmd_dat, cmd_sel} = c;
            @(posedge clk_100MHz);
            exp_q.push_back(c);
            occ++;
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int i = 0;
        while (n_rsp < target && i < budget) begin
            @(posedge clk_100MHz);
            i++;
        end
        @(negedge clk_100MHz);
        check("rsp_count", n_rsp, target);
    endtask

    task automatic wait_cyc(input int budget);
        int i = 0;
        while (!wb_cyc_o && i < budget) begin
            @(negedge clk_100MHz);
            i++;
        end
        check("cyc_seen", wb_cyc_o, 1'b1);
    endtask

    task automatic check_reset_vals();
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_we", wb_we_o, 1'b0);
        check("rst_sel", wb_sel_o, 4'h0);
        check("rst_adr", wb_adr_o, 27'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_dat", rsp_dat, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we  = 1'($urandom_range(0, 1));
        c.adr = 27'($urandom);
        c.dat = $urandom;
        c.sel = 4'($urandom);
        return c;
    endfunction

    initial begin
        int base;
        int nb;

        // Power-on reset
        repeat (3) @(negedge clk_100MHz);
        check_reset_vals();
        reset_n = 1'b1;
        @(posedge clk_100MHz);
        #1 mon_en = 1'b1;

        // Single write, ack on the alternate phase
        ack_delay = 2;
        base = n_rsp;
        nb   = n_bus;
        push({1'b1, 27'h000_0003, 32'h0000_000A, 4'hF});
        wait_rsp(base + 1, 50);
        check("single_bus_count", n_bus, nb + 1);

        // Read
        push({1'b0, 27'h000_1010, 32'h0, 4'hF});
        wait_rsp(base + 2, 50);
        check("read_data", rsp_dat, 32'hDEAD_BEEF);

        // Burst of 4 queued behind a slow command: FIFO fills, drains in order
        ack_delay = 5;
        base = n_rsp;
        push(rand_cmd());
        wait_cyc(20);
        for (int i = 0; i < 4; i++) push({1'b1, 27'(32'h100 + i), 32'(i * 3 + 1), 4'h3});
        @(negedge clk_100MHz);
        check("full_after_burst", cmd_ready, 1'b0);
        wait_rsp(base + 5, 200);

        // Stale ack held for 2 cycles
        ack_delay = 1;
        ack_hold  = 2;
        base = n_rsp;
        nb   = n_bus;
        push(rand_cmd());
        push(rand_cmd());
        wait_rsp(base + 2, 60);
        repeat (10) @(negedge clk_100MHz);
        check("stale_rsp_count", n_rsp, base + 2);
        check("stale_bus_count", n_bus, nb + 2);

        // Random traffic
        base = n_rsp;
        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(1, 2);
            ack_hold  = $urandom_range(1, 2);
            push(rand_cmd());
            repeat ($urandom_range(0, 3)) @(posedge clk_100MHz);
        end
        wait_rsp(base + 40, 1000);
        ack_hold = 1;

        // Slave never acks
        ack_never = 1'b1;
        base = n_rsp;
        push(rand_cmd());
`ifdef WB_MASTER_TIMEOUT_EN
        wait_rsp(base + 1, 40);
        check("timeout_err", rsp_err, 1'b0);
        ack_never = 1'b0;
        push({1'b0, 27'h000_1010, 32'h0, 4'hF});
        wait_rsp(base + 2, 40);
        check("after_timeout_read", rsp_dat, 32'hDEAD_BEEF);
        ack_never = 1'b1;
`else
        repeat (40) @(negedge clk_100MHz);
        check("stall_no_rsp", n_rsp, base);
        check("stall_cyc", wb_cyc_o, 1'b1);
`endif

        // Reset during ACTIVE with two commands queued
        repeat (TmoEn ? 3 : 2) push(rand_cmd());
        wait_cyc(20);
        check("queued_busy", busy, 1'b1);
        base = n_rsp;
        nb   = n_bus;
        @(posedge clk_100MHz);
        #1 mon_en = 1'b0;
        @(negedge clk_100MHz);
        reset_n = 1'b0;
        @(negedge clk_100MHz);
        check_reset_vals();
        reset_n   = 1'b1;
        ack_never = 1'b0;
        exp_q.delete();
        occ       = 0;
        prev_occ  = 0;
        in_flight = 1'b0;
        prev_cyc  = 1'b0;
        prev_ack  = 1'b0;
        prev_gap  = 1'b0;
        cur       = '0;
        last_rdat = '0;
        len       = 0;
        @(posedge clk_100MHz);
        #1 mon_en = 1'b1;
        repeat (8) @(negedge clk_100MHz);
        check("discarded_no_bus", n_bus, nb);
        check("discarded_no_rsp", n_rsp, base);
        check("discarded_busy", busy, 1'b0);

        // Normal operation after reset
        ack_delay = 2;
        push({1'b1, 27'h000_0040, 32'h1234_5678, 4'h5});
        push({1'b0, 27'h000_1010, 32'h0, 4'hF});
        wait_rsp(base + 2, 60);
        check("post_reset_read", rsp_dat, 32'hDEAD_BEEF);

        repeat (4) @(negedge clk_100MHz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
